// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory port controller.
//   state_e    : controller FSM states
//   RD_LAT_MAX : largest supported memory read latency
//   LAT_CNT_W  : width of the read-latency down-counter
//   lat_load   : counter preload for a given read latency
package mem_port_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned LAT_CNT_W  = $clog2(RD_LAT_MAX);

  // WAIT spans rd_lat cycles and ends on the cycle the counter reads zero.
  function automatic logic [LAT_CNT_W-1:0] lat_load(input int unsigned rd_lat);
    return LAT_CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Request/response and memory-side bus of the memory port controller.
//   slave  : controller view (takes requests, drives responses and the memory port)
//   master : requester/memory view (drives requests and read data)
interface mem_port_ctrl_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_ena;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [DATA_W-1:0] mem_dina;
  logic [DATA_W-1:0] mem_douta;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_douta,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_ena, mem_wea, mem_addra, mem_dina
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_douta,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_ena, mem_wea, mem_addra, mem_dina
  );

endinterface

// File: rtl/rd_lat_counter.sv
// Read-latency down-counter.
//   sysclk   : clock
//   rst      : synchronous active-low reset (clears the count)
//   load     : load load_val (has priority over dec)
//   load_val : preload value
//   dec      : decrement, saturating at zero
//   zero     : count is zero
module rd_lat_counter
  import mem_port_pkg::*;
(
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-outstanding request controller in front of a synchronous single-port memory.
//   sysclk    : clock
//   rst       : synchronous active-low reset
//   mem_clka  : memory clock (sysclk forwarded)
//   bus       : request/response handshake plus memory port (mem_port_ctrl_if.slave)
// Optional feature: define DM_BOUNDS_CHECK_EN to reject addresses >= DEPTH with rsp_err=1
// and no memory access; otherwise rsp_err is 0 and every address is issued unchanged.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2 ** ADDR_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  sysclk,
  input  logic                  rst,
  output logic                  mem_clka,
  mem_port_ctrl_if.slave        bus
);

  if ((RD_LAT < 1) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
    $error("mem_port_ctrl: RD_LAT out of range");
  end
  if ((DEPTH < 1) || (DEPTH > 2 ** ADDR_W)) begin : g_bad_depth
    $error("mem_port_ctrl: DEPTH out of range");
  end

  localparam logic [LAT_CNT_W-1:0] LatLoad = lat_load(RD_LAT);

  state_e              state_q, state_d;
  logic                hold_we_q;
  logic [ADDR_W-1:0]   hold_addr_q;
  logic [DATA_W-1:0]   hold_wdata_q;
  logic [ADDR_W-1:0]   last_addr_q;
  logic [DATA_W-1:0]   last_wdata_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                accept;
  logic                addr_ok;
  logic                lat_load_en;
  logic                lat_dec;
  logic                lat_zero;

  assign accept = (state_q == StIdle) && bus.req_valid;

`ifdef DM_BOUNDS_CHECK_EN
  logic err_q;

  assign addr_ok = (32'(hold_addr_q) < DEPTH);

  always_ff @(posedge sysclk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((state_q == StIssue) && !addr_ok) begin
      err_q <= 1'b1;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign addr_ok     = 1'b1;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    lat_load_en = 1'b0;
    lat_dec     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = StIssue;
          // Writes and rejected accesses respond with zero data.
          rdata_d = '0;
        end
      end
      StIssue: begin
        if (!addr_ok || hold_we_q) begin
          state_d = StResp;
        end else begin
          state_d     = StWait;
          lat_load_en = 1'b1;
        end
      end
      StWait: begin
        if (lat_zero) begin
          rdata_d = bus.mem_douta;
          state_d = StResp;
        end else begin
          lat_dec = 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst) begin
      state_q      <= StIdle;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (accept) begin
        hold_we_q    <= bus.req_we;
        hold_addr_q  <= bus.req_addr;
        hold_wdata_q <= bus.req_wdata;
      end
      // Remember what was last presented so the memory bus stays quiet between accesses.
      if (state_q == StIssue) begin
        last_addr_q  <= hold_addr_q;
        last_wdata_q <= hold_wdata_q;
      end
    end
  end

  rd_lat_counter u_lat_cnt (
    .sysclk   (sysclk),
    .rst      (rst),
    .load     (lat_load_en),
    .load_val (LatLoad),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  assign mem_clka      = sysclk;
  assign bus.req_ready = (state_q == StIdle) && rst;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_ena   = (state_q == StIssue) && addr_ok;
  assign bus.mem_wea   = (state_q == StIssue) && addr_ok && hold_we_q;
  assign bus.mem_addra = (state_q == StIssue) ? hold_addr_q : last_addr_q;
  assign bus.mem_dina  = (state_q == StIssue) ? hold_wdata_q : last_wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: three instances (RD_LAT 1/DEPTH 100, RD_LAT 3, RD_LAT 4), each
// with a behavioural memory of matching read latency, exercised by directed scenarios.
module tb_mem_port_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        req_valid [3];
  logic        req_we    [3];
  logic [6:0]  req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_ready [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        mem_ena   [3];
  logic        mem_wea   [3];
  logic [6:0]  mem_addra [3];
  logic        mem_clka  [3];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat   = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int unsigned Depth = (g == 0) ? 100 : 128;

    mem_port_ctrl_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    mem_port_ctrl #(
      .ADDR_W (7),
      .DATA_W (32),
      .DEPTH  (Depth),
      .RD_LAT (Lat)
    ) u_dut (
      .sysclk   (clk),
      .rst      (rst),
      .mem_clka (mem_clka[g]),
      .bus      (bus)
    );

    logic [31:0] mem  [128];
    logic [31:0] pipe [4];

    initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 + i;
      for (int k = 0; k < 4; k++) pipe[k] = 32'h0;
    end

    always @(posedge clk) begin
      if (bus.mem_ena) begin
        if (bus.mem_wea) mem[bus.mem_addra] <= bus.mem_dina;
        else             pipe[0] <= mem[bus.mem_addra];
      end
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign bus.mem_douta = pipe[Lat-1];
    assign bus.req_valid = req_valid[g];
    assign bus.req_we    = req_we[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    assign rsp_err[g]    = bus.rsp_err;
    assign mem_ena[g]    = bus.mem_ena;
    assign mem_wea[g]    = bus.mem_wea;
    assign mem_addra[g]  = bus.mem_addra;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction; lat counts edges from the accept edge (=1) to the first rsp_valid sample.
  task automatic do_req(input int sel, input logic we, input logic [6:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic err, output int ena_cycles);
    int guard;
    lat        = 99;
    rdata      = 32'hBAD0_BAD0;
    err        = 1'b0;
    ena_cycles = 0;
    guard      = 0;
    while (!req_ready[sel] && guard < 20) begin
      step();
      guard++;
    end
    req_valid[sel] = 1'b1;
    req_we[sel]    = we;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    step();
    req_valid[sel] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_ena[sel]) ena_cycles++;
      if (rsp_valid[sel]) begin
        lat   = c;
        rdata = rsp_rdata[sel];
        err   = rsp_err[sel];
        break;
      end
      step();
    end
    if (lat != 99) begin
      rsp_ready[sel] = 1'b1;
      step();
      rsp_ready[sel] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    for (int s = 0; s < 3; s++) begin
      total++;
      if (req_ready[s] !== 1'b0) begin
        bad++;
        $display("FAIL rst_ready_low[%0d]: got %b want 0", s, req_ready[s]);
      end
    end
    step();
    rst = 1'b1;
    step();
    for (int s = 0; s < 3; s++) begin
      total++;
      if ({req_ready[s], rsp_valid[s], mem_ena[s], rsp_err[s]} !== 4'b1000) begin
        bad++;
        $display("FAIL rst_ctrl[%0d]: got rdy/vld/ena/err=%b%b%b%b want 1000", s,
                 req_ready[s], rsp_valid[s], mem_ena[s], rsp_err[s]);
      end
      total++;
      if ({rsp_rdata[s], mem_addra[s]} !== 39'h0) begin
        bad++;
        $display("FAIL rst_data[%0d]: got rdata=%h addr=%h want 0", s, rsp_rdata[s],
                 mem_addra[s]);
      end
    end
  endtask

  task automatic test_write_read();
    int lat, ena;
    logic [31:0] rd;
    logic err;
    do_req(0, 1'b1, 7'h05, 32'hDEAD_BEEF, lat, rd, err, ena);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL wr_lat: got %0d want 2", lat); end
    total++;
    if ({rd, err} !== 33'h0) begin
      bad++; $display("FAIL wr_rsp: got rdata=%h err=%b want 0/0", rd, err);
    end
    total++;
    if (ena !== 1) begin bad++; $display("FAIL wr_ena: got %0d want 1", ena); end
    do_req(0, 1'b0, 7'h05, 32'h0, lat, rd, err, ena);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL rd1_lat: got %0d want 3", lat); end
    total++;
    if (rd !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL rd1_data: got %h want deadbeef", rd);
    end
    do_req(0, 1'b1, 7'h06, 32'h0000_0001, lat, rd, err, ena);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL wr_after_rd_data: got %h want 0", rd); end
    total++;
    if ({mem_addra[0], mem_ena[0], mem_wea[0]} !== {7'h06, 2'b00}) begin
      bad++;
      $display("FAIL mem_hold: got addr=%h ena=%b wea=%b want 06/0/0", mem_addra[0],
               mem_ena[0], mem_wea[0]);
    end
  endtask

  task automatic test_read_lat3();
    int lat, ena;
    logic [31:0] rd;
    logic err;
    do_req(1, 1'b0, 7'h10, 32'h0, lat, rd, err, ena);
    total++;
    if (lat !== 5) begin bad++; $display("FAIL rd3_lat: got %0d want 5", lat); end
    total++;
    if (rd !== 32'hA500_0010) begin bad++; $display("FAIL rd3_data: got %h want a5000010", rd); end
    total++;
    if (ena !== 1) begin bad++; $display("FAIL rd3_ena: got %0d want 1", ena); end
  endtask

  task automatic test_back_to_back();
    int guard;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 7'h05;
    step();
    req_valid[0] = 1'b0;
    guard = 0;
    while (!rsp_valid[0] && guard < 20) begin step(); guard++; end
    // Present the next request during the stall; it must wait for IDLE.
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 7'h07;
    req_wdata[0] = 32'h0000_0077;
    for (int c = 0; c < 4; c++) begin
      total++;
      if ({rsp_valid[0], req_ready[0], mem_ena[0]} !== 3'b100 || rsp_rdata[0] !== 32'hDEAD_BEEF)
      begin
        bad++;
        $display("FAIL stall[%0d]: got vld/rdy/ena=%b%b%b rdata=%h want 100/deadbeef", c,
                 rsp_valid[0], req_ready[0], mem_ena[0], rsp_rdata[0]);
      end
      step();
    end
    rsp_ready[0] = 1'b1;
    step();
    rsp_ready[0] = 1'b0;
    total++;
    if ({req_ready[0], rsp_valid[0], mem_ena[0]} !== 3'b100) begin
      bad++;
      $display("FAIL post_hs_idle: got rdy/vld/ena=%b%b%b want 100", req_ready[0],
               rsp_valid[0], mem_ena[0]);
    end
    step();
    req_valid[0] = 1'b0;
    total++;
    if ({mem_ena[0], mem_wea[0], mem_addra[0]} !== {2'b11, 7'h07}) begin
      bad++;
      $display("FAIL b2b_issue: got ena=%b wea=%b addr=%h want 1/1/07", mem_ena[0],
               mem_wea[0], mem_addra[0]);
    end
    guard = 0;
    while (!rsp_valid[0] && guard < 20) begin step(); guard++; end
    total++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h0) begin
      bad++;
      $display("FAIL b2b_rsp: got vld=%b rdata=%h want 1/0", rsp_valid[0], rsp_rdata[0]);
    end
    rsp_ready[0] = 1'b1;
    step();
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_bounds();
    int lat, ena;
    logic [31:0] rd;
    logic err;
    int exp_wlat, exp_rlat, exp_ena;
    logic exp_err;
    logic [31:0] exp_rd;
`ifdef DM_BOUNDS_CHECK_EN
    exp_wlat = 2; exp_rlat = 2; exp_ena = 0; exp_err = 1'b1; exp_rd = 32'h0;
`else
    exp_wlat = 2; exp_rlat = 3; exp_ena = 1; exp_err = 1'b0; exp_rd = 32'h1234_5678;
`endif
    do_req(0, 1'b1, 7'd120, 32'h1234_5678, lat, rd, err, ena);
    total++;
    if (lat !== exp_wlat || ena !== exp_ena) begin
      bad++;
      $display("FAIL oob_wr: got lat=%0d ena=%0d want %0d/%0d", lat, ena, exp_wlat, exp_ena);
    end
    total++;
    if (err !== exp_err || rd !== 32'h0) begin
      bad++;
      $display("FAIL oob_wr_rsp: got err=%b rdata=%h want %b/0", err, rd, exp_err);
    end
    do_req(0, 1'b0, 7'd120, 32'h0, lat, rd, err, ena);
    total++;
    if (lat !== exp_rlat || ena !== exp_ena) begin
      bad++;
      $display("FAIL oob_rd: got lat=%0d ena=%0d want %0d/%0d", lat, ena, exp_rlat, exp_ena);
    end
    total++;
    if (err !== exp_err || rd !== exp_rd) begin
      bad++;
      $display("FAIL oob_rd_rsp: got err=%b rdata=%h want %b/%h", err, rd, exp_err, exp_rd);
    end
  endtask

  task automatic test_reset_mid_read();
    int lat, ena, seen;
    logic [31:0] rd;
    logic err;
    do_req(2, 1'b1, 7'h03, 32'hCAFE_F00D, lat, rd, err, ena);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 7'h03;
    step();
    req_valid[2] = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    total++;
    if ({rsp_valid[2], req_ready[2], mem_ena[2]} !== 3'b000) begin
      bad++;
      $display("FAIL mid_rst: got vld/rdy/ena=%b%b%b want 000", rsp_valid[2], req_ready[2],
               mem_ena[2]);
    end
    rst = 1'b1;
    #1;
    total++;
    if (req_ready[2] !== 1'b1) begin
      bad++; $display("FAIL mid_rst_idle: got rdy=%b want 1", req_ready[2]);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid[2]) seen++;
      step();
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL mid_rst_no_rsp: got %0d want 0", seen); end
    do_req(2, 1'b0, 7'h03, 32'h0, lat, rd, err, ena);
    total++;
    if (lat !== 6 || rd !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL rd4_after_rst: got lat=%0d rdata=%h want 6/cafef00d", lat, rd);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      req_valid[s] = 1'b0;
      req_we[s]    = 1'b0;
      req_addr[s]  = 7'h0;
      req_wdata[s] = 32'h0;
      rsp_ready[s] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_read_lat3();
    test_back_to_back();
    test_bounds();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, memory word-address width.
REQ-002 Parameter DATA_W, default 32, memory word width.
REQ-003 Parameter DEPTH, default 2**ADDR_W, number of implemented words; legal range 1..2**ADDR_W.
REQ-004 Parameter RD_LAT, default 1, memory read latency in cycles; legal range 1..4.
REQ-005 Ports:
- sysclk  in  1  the single clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  out-of-range access.
- mem_clka  out  1  memory clock, equal to sysclk.
- mem_ena  out  1  memory enable.
- mem_wea  out  1  memory write enable.
- mem_addra  out  ADDR_W  memory address.
- mem_dina  out  DATA_W  memory write data.
- mem_douta  in  DATA_W  memory read data.

Function
REQ-006 FSM states are IDLE, ISSUE, WAIT and RESP; the FSM holds at most one outstanding request.
REQ-007 IDLE: req_ready=1; when req_valid=1, capture we/addr/wdata into holding registers and go to ISSUE.
REQ-008 req_ready SHALL be 0 in every state except IDLE.
REQ-009 ISSUE, one cycle:
- drive mem_ena=1, mem_wea=held we, mem_addra=held addr, mem_dina=held wdata;
- next state is RESP for a write, or WAIT for a read with the latency counter loaded to RD_LAT-1.
REQ-010 WAIT lasts exactly RD_LAT cycles:
- counter decrements each cycle;
- in the cycle the counter is 0, register mem_douta into rsp_rdata and go to RESP.
REQ-011 RESP: rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready=1; then go to IDLE.
REQ-012 Latency from the accept edge to the first rsp_valid cycle: write = 2 cycles, read = RD_LAT+2 cycles.
REQ-013 Back-to-back requests: a new request is accepted in the IDLE cycle that follows a RESP handshake; there is no accept in the same cycle as the handshake.
REQ-014 Outside ISSUE: mem_ena=0 and mem_wea=0; mem_addra and mem_dina hold their last values.
REQ-015 A write response carries rsp_rdata=0.
REQ-016 A held rsp_ready=0 stalls indefinitely in RESP with no memory activity.

Reset
REQ-017 When rst=0 at a sysclk edge, the block SHALL:
- go to IDLE;
- clear rsp_valid, rsp_rdata, rsp_err, mem_ena, mem_wea, mem_addra, mem_dina, the latency counter and the holding registers.
REQ-018 Reset mid-operation discards the in-flight request with no response; a write whose ISSUE edge has already occurred remains in memory.
REQ-019 req_ready SHALL be 0 while rst=0.

Configuration
REQ-020 Macro DM_BOUNDS_CHECK_EN defined, for a request with addr>=DEPTH:
- ISSUE keeps mem_ena=0;
- the FSM goes directly to RESP with rsp_err=1 and rsp_rdata=0.
REQ-021 Macro DM_BOUNDS_CHECK_EN undefined: rsp_err is tied to 0 and every address is issued unchanged.

Structure
REQ-022 Package mem_port_pkg SHALL hold the FSM state enum, RD_LAT_MAX=4 and the latency-counter width constant.
REQ-023 The latency counter SHALL be the sub-module rd_lat_counter (load, decrement, zero flag).

Verification
REQ-024 Reset: rst=0 for 2 cycles, then rst=1 -> state IDLE, req_ready=1, rsp_valid=0, mem_ena=0.
REQ-025 Write then read, RD_LAT=1: write addr 0x05 data 0xDEADBEEF, then read addr 0x05 ->
- write rsp_valid 2 cycles after accept;
- read rsp_valid 3 cycles after accept with rsp_rdata=0xDEADBEEF.
REQ-026 Read, RD_LAT=3: read addr 0x10 -> rsp_valid 5 cycles after accept; mem_ena high for exactly 1 cycle.
REQ-027 Backpressure: rsp_ready=0 for 4 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, mem_ena=0 throughout; accept resumes 1 cycle after the handshake.
REQ-028 Bounds, DEPTH=100, DM_BOUNDS_CHECK_EN defined: write addr 120 -> mem_ena never asserted, rsp_err=1; a following read of addr 120 -> rsp_rdata=0, rsp_err=1.
REQ-029 Reset mid-read, RD_LAT=4: rst=0 in the second WAIT cycle -> no rsp_valid, IDLE on the next cycle; the next read returns correct data.
